seg_display_scanner: RTL and testbench



---
 rtl/seg_display_pkg.sv | 32 +++
 rtl/seg_display_scanner_if.sv | 27 ++
 rtl/seg_scan_timer.sv | 34 +++
 rtl/seg_display_scanner.sv | 103 ++++++++++
 tb/tb_seg_display_scanner.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared 7-segment glyph constants and code-to-glyph decode.
package seg_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_TABLE [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

    // Active-low gfedcba pattern; codes above 9 are blank unless hex_mode is set.
    function automatic logic [6:0] seg_glyph(input logic [3:0] code, input logic hex_mode);
        return (code > 4'd9 && !hex_mode) ? SEG_BLANK : SEG_TABLE[code];
    endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// seg_display_scanner_if: data/control in, anode/cathode pins out. SEG_BLINK_EN adds blink_mask.
interface seg_display_scanner_if #(parameter int NUM_DIGITS = 8);

    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    hex_mode;
    logic                    lz_en;
    logic [3:0]              brightness;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   seg_sel;
`ifdef SEG_BLINK_EN
    logic [NUM_DIGITS-1:0]   blink_mask;

    modport master(output digits_in, dp_in, load, hex_mode, lz_en, brightness, blink_mask,
                   input seg_out, dp_out, seg_sel);
    modport slave(input digits_in, dp_in, load, hex_mode, lz_en, brightness, blink_mask,
                  output seg_out, dp_out, seg_sel);
`else
    modport master(output digits_in, dp_in, load, hex_mode, lz_en, brightness,
                   input seg_out, dp_out, seg_sel);
    modport slave(input digits_in, dp_in, load, hex_mode, lz_en, brightness,
                  output seg_out, dp_out, seg_sel);
`endif

endinterface

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: refresh prescaler, digit index, frame boundary and brightness PWM window.
module seg_scan_timer #(
    parameter int NUM_DIGITS = 8,
    parameter int REFRESH_DIV_LOG2 = 16,
    localparam int IDX_W = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       brightness,
    output logic [IDX_W-1:0] idx,
    output logic             frame_end,
    output logic             pwm_on
);

    logic [REFRESH_DIV_LOG2-1:0] prescaler;
    logic                        tick;

    assign tick      = &prescaler;
    assign frame_end = tick && idx == IDX_W'(NUM_DIGITS - 1);
    assign pwm_on    = prescaler[REFRESH_DIV_LOG2-1 -: 4] <= brightness;

    // Free-running slot counter; the digit index advances once per full slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (tick)
                idx <= frame_end ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: double-buffered multiplexed 7-segment scanner; optional SEG_BLINK_EN blinking.
module seg_display_scanner
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int REFRESH_DIV_LOG2 = 16,
`ifdef SEG_BLINK_EN
    parameter int BLINK_FRAMES = 256,
`endif
    localparam int IDX_W = $clog2(NUM_DIGITS)
) (
    input logic clk,
    input logic rst,
    seg_display_scanner_if.slave bus
);

    logic [IDX_W-1:0]        idx;
    logic                    frame_end;
    logic                    pwm_on;
    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [4*NUM_DIGITS-1:0] active_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic                    pending;
    logic [3:0]              cur_code;
    logic                    suppressed;
    logic                    anode_en;

    seg_scan_timer #(
        .NUM_DIGITS(NUM_DIGITS),
        .REFRESH_DIV_LOG2(REFRESH_DIV_LOG2)
    ) u_timer (
        .clk(clk),
        .rst(rst),
        .brightness(bus.brightness),
        .idx(idx),
        .frame_end(frame_end),
        .pwm_on(pwm_on)
    );

    // Loads land in the shadow copy; active only changes on a frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            active_digits <= '0;
            active_dp     <= '0;
            pending       <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow_digits <= bus.digits_in;
                shadow_dp     <= bus.dp_in;
            end
            if (frame_end && bus.load) begin
                active_digits <= bus.digits_in;
                active_dp     <= bus.dp_in;
            end else if (frame_end && pending) begin
                active_digits <= shadow_digits;
                active_dp     <= shadow_dp;
            end
            pending <= bus.load ? !frame_end : (frame_end ? 1'b0 : pending);
        end
    end

    assign cur_code   = active_digits[{idx, 2'b00} +: 4];
    assign suppressed = bus.lz_en && idx != '0 && (active_digits >> {idx, 2'b00}) == '0;

`ifdef SEG_BLINK_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);

    logic [FC_W-1:0] frame_cnt;
    logic            blink_on;

    // Counts frames and flips the blink phase every BLINK_FRAMES frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt == FC_W'(BLINK_FRAMES - 1) ? '0 : frame_cnt + 1'b1;
            blink_on  <= frame_cnt == FC_W'(BLINK_FRAMES - 1) ? !blink_on : blink_on;
        end
    end

    assign anode_en = pwm_on && !(bus.blink_mask[idx] && !blink_on);
`else
    assign anode_en = pwm_on;
`endif

    // Registered pins: anode and cathodes switch together, so only one anode is ever low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.seg_out <= SEG_BLANK;
            bus.dp_out  <= 1'b1;
            bus.seg_sel <= '1;
        end else begin
            bus.seg_out <= suppressed ? SEG_BLANK : seg_glyph(cur_code, bus.hex_mode);
            bus.dp_out  <= !active_dp[idx];
            bus.seg_sel <= anode_en ? ~(NUM_DIGITS'(1) << idx) : '1;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner: randomized and directed checks against a frame/slot-level reference model.
module tb_seg_display_scanner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seg_display_scanner_if #(.NUM_DIGITS(8)) bus();

    seg_display_scanner #(
        .NUM_DIGITS(8),
        .REFRESH_DIV_LOG2(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] GLY [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: cyc counts clocks since reset; slot = cyc/16 mod 8, phase = cyc mod 16.
    int         cyc;
    logic [3:0] m_active [8];
    logic [3:0] m_shadow [8];
    logic [7:0] m_dp_a, m_dp_s;
    logic       m_pend;
    logic [7:0] exp_sel;
    logic [6:0] exp_seg;
    logic       exp_dp;

    function automatic logic [6:0] ref_seg(int s);
        logic blank;
        blank = bus.lz_en && s > 0;
        for (int j = s; j < 8; j++)
            if (m_active[j] != 4'd0) blank = 1'b0;
        if (blank) return 7'h7F;
        if (m_active[s] > 4'd9 && !bus.hex_mode) return 7'h7F;
        return GLY[m_active[s]];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc     <= 0;
            m_pend  <= 1'b0;
            m_dp_a  <= '0;
            m_dp_s  <= '0;
            exp_sel <= 8'hFF;
            exp_seg <= 7'h7F;
            exp_dp  <= 1'b1;
            for (int i = 0; i < 8; i++) begin
                m_active[i] <= '0;
                m_shadow[i] <= '0;
            end
        end else begin
            exp_sel <= ((cyc % 16) <= int'(bus.brightness)) ? ~(8'd1 << ((cyc / 16) % 8)) : 8'hFF;
            exp_seg <= ref_seg((cyc / 16) % 8);
            exp_dp  <= !m_dp_a[(cyc / 16) % 8];
            if (bus.load) begin
                for (int i = 0; i < 8; i++) m_shadow[i] <= bus.digits_in[4*i +: 4];
                m_dp_s <= bus.dp_in;
            end
            if (cyc % 128 == 127 && bus.load) begin
                for (int i = 0; i < 8; i++) m_active[i] <= bus.digits_in[4*i +: 4];
                m_dp_a <= bus.dp_in;
                m_pend <= 1'b0;
            end else if (bus.load) begin
                m_pend <= 1'b1;
            end else if (cyc % 128 == 127 && m_pend) begin
                for (int i = 0; i < 8; i++) m_active[i] <= m_shadow[i];
                m_dp_a <= m_dp_s;
                m_pend <= 1'b0;
            end
            cyc <= cyc + 1;
        end
    end

    function automatic int low_digit(logic [7:0] sel);
        for (int i = 0; i < 8; i++)
            if (!sel[i]) return i;
        return -1;
    endfunction

    task automatic do_load(logic [31:0] d, logic [7:0] p);
        bus.digits_in = d;
        bus.dp_in     = p;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load      = 1'b0;
    endtask

    task automatic wait_frame_start();
        @(negedge clk);
        for (int k = 0; k < 300 && cyc % 128 != 0; k++) @(negedge clk);
        checks++;
        if (cyc % 128 != 0) begin
            errors++;
            $display("FAIL frame_wait timeout cyc=%0d", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.digits_in  = '0;
        bus.dp_in      = '0;
        bus.load       = 1'b0;
        bus.hex_mode   = 1'b0;
        bus.lz_en      = 1'b0;
        bus.brightness = 4'd15;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.seg_sel !== 8'hFF || bus.seg_out !== 7'h7F || bus.dp_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_vals sel=%h seg=%h dp=%b want FF/7F/1", bus.seg_sel, bus.seg_out, bus.dp_out);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.seg_sel !== 8'hFE || bus.seg_out !== 7'h40) begin
            errors++;
            $display("FAIL reset_first_slot sel=%h seg=%h want FE/40", bus.seg_sel, bus.seg_out);
        end
    endtask

    task automatic test_lz();
        logic [6:0] want_lz [8] = '{7'h78, 7'h40, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        logic [6:0] want_nz [8] = '{7'h78, 7'h40, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        int d;
        bus.lz_en = 1'b1;
        bus.hex_mode = 1'b0;
        bus.brightness = 4'd15;
        do_load(32'h0000_0407, 8'h04);
        wait_frame_start();
        for (int pass = 0; pass < 2; pass++) begin
            for (int n = 0; n < 128; n++) begin
                @(negedge clk);
                d = low_digit(bus.seg_sel);
                checks++;
                if (bus.seg_sel !== exp_sel || bus.seg_out !== exp_seg || bus.dp_out !== exp_dp) begin
                    errors++;
                    $display("FAIL lz_model pass=%0d sel=%h/%h seg=%h/%h dp=%b/%b", pass,
                             bus.seg_sel, exp_sel, bus.seg_out, exp_seg, bus.dp_out, exp_dp);
                end
                checks++;
                if (d < 0 || bus.seg_out !== (pass == 0 ? want_lz[d] : want_nz[d])) begin
                    errors++;
                    $display("FAIL lz_glyph pass=%0d digit=%0d seg=%h", pass, d, bus.seg_out);
                end
            end
            bus.lz_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_hex();
        int d;
        bus.lz_en = 1'b1;
        bus.hex_mode = 1'b1;
        do_load(32'h0000_00AF, 8'h00);
        wait_frame_start();
        for (int pass = 0; pass < 2; pass++) begin
            for (int n = 0; n < 128; n++) begin
                @(negedge clk);
                d = low_digit(bus.seg_sel);
                checks++;
                if (bus.seg_sel !== exp_sel || bus.seg_out !== exp_seg || bus.dp_out !== exp_dp) begin
                    errors++;
                    $display("FAIL hex_model pass=%0d sel=%h/%h seg=%h/%h", pass,
                             bus.seg_sel, exp_sel, bus.seg_out, exp_seg);
                end
                checks++;
                if (bus.seg_out !== ((pass == 0 && d == 0) ? 7'h0E : (pass == 0 && d == 1) ? 7'h08 : 7'h7F)) begin
                    errors++;
                    $display("FAIL hex_glyph pass=%0d digit=%0d seg=%h", pass, d, bus.seg_out);
                end
            end
            bus.hex_mode = 1'b0;
            @(negedge clk);
        end
        bus.hex_mode = 1'b1;
    endtask

    task automatic test_pwm();
        int cnt [8];
        logic [3:0] levels [3] = '{4'd3, 4'd0, 4'd15};
        for (int l = 0; l < 3; l++) begin
            bus.brightness = levels[l];
            @(negedge clk);
            for (int i = 0; i < 8; i++) cnt[i] = 0;
            for (int n = 0; n < 128; n++) begin
                @(negedge clk);
                for (int i = 0; i < 8; i++) if (!bus.seg_sel[i]) cnt[i]++;
                checks++;
                if ($countones(~bus.seg_sel) > 1 || bus.seg_sel !== exp_sel) begin
                    errors++;
                    $display("FAIL pwm_sel level=%0d sel=%h want %h", levels[l], bus.seg_sel, exp_sel);
                end
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (cnt[i] != int'(levels[l]) + 1) begin
                    errors++;
                    $display("FAIL pwm_duty level=%0d digit=%0d low=%0d want %0d", levels[l], i, cnt[i], levels[l] + 1);
                end
            end
        end
    endtask

    task automatic test_buffer();
        int d;
        bus.lz_en = 1'b0;
        bus.hex_mode = 1'b1;
        bus.brightness = 4'd15;
        do_load(32'h0000_0000, 8'h00);
        wait_frame_start();
        for (int k = 0; k < 300 && (cyc / 16) % 8 != 3; k++) @(negedge clk);
        do_load(32'h1234_5678, 8'hFF);
        while (cyc % 128 != 1) begin
            d = low_digit(bus.seg_sel);
            checks++;
            if (bus.seg_sel !== exp_sel || bus.seg_out !== exp_seg || (d >= 4 && bus.seg_out !== 7'h40) || bus.dp_out !== 1'b1) begin
                errors++;
                $display("FAIL buf_midframe digit=%0d seg=%h/%h dp=%b", d, bus.seg_out, exp_seg, bus.dp_out);
            end
            @(negedge clk);
        end
        for (int n = 0; n < 128; n++) begin
            d = low_digit(bus.seg_sel);
            checks++;
            if (bus.seg_sel !== exp_sel || bus.seg_out !== exp_seg || bus.dp_out !== exp_dp ||
                (d == 0 && bus.seg_out !== 7'h00) || (d == 4 && bus.seg_out !== 7'h19)) begin
                errors++;
                $display("FAIL buf_newframe digit=%0d seg=%h/%h dp=%b/%b", d, bus.seg_out, exp_seg, bus.dp_out, exp_dp);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 300 && cyc % 128 != 127; k++) @(negedge clk);
        do_load(32'h8765_4321, 8'h01);
        @(negedge clk);
        checks++;
        if (bus.seg_sel !== 8'hFE || bus.seg_out !== 7'h79 || bus.dp_out !== 1'b0) begin
            errors++;
            $display("FAIL buf_at_frame_end sel=%h seg=%h dp=%b want FE/79/0", bus.seg_sel, bus.seg_out, bus.dp_out);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 300 && (cyc / 16) % 8 != 5; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.seg_sel !== 8'hFF || bus.seg_out !== 7'h7F || bus.dp_out !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_now sel=%h seg=%h dp=%b", bus.seg_sel, bus.seg_out, bus.dp_out);
        end
        @(negedge clk);
        checks++;
        if (bus.seg_sel !== 8'hFF || bus.seg_out !== 7'h7F || bus.dp_out !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_edge sel=%h seg=%h dp=%b", bus.seg_sel, bus.seg_out, bus.dp_out);
        end
        bus.brightness = 4'd2;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 40 && bus.seg_sel === 8'hFF; k++) @(negedge clk);
        checks++;
        if (bus.seg_sel !== 8'hFE) begin
            errors++;
            $display("FAIL async_restart sel=%h want FE", bus.seg_sel);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            checks++;
            if (bus.seg_sel !== exp_sel || bus.seg_out !== exp_seg || bus.dp_out !== exp_dp ||
                $countones(~bus.seg_sel) > 1) begin
                errors++;
                $display("FAIL random n=%0d sel=%h/%h seg=%h/%h dp=%b/%b", n,
                         bus.seg_sel, exp_sel, bus.seg_out, exp_seg, bus.dp_out, exp_dp);
            end
            bus.load = ($urandom_range(0, 29) == 0);
            if (bus.load) begin
                bus.digits_in = ($urandom_range(0, 1) == 0) ? $urandom() : ($urandom() >> $urandom_range(4, 31));
                bus.dp_in     = 8'($urandom());
            end
            if ($urandom_range(0, 99) == 0) begin
                bus.hex_mode   = 1'($urandom());
                bus.lz_en      = 1'($urandom());
                bus.brightness = 4'($urandom());
            end
        end
        bus.load = 1'b0;
    endtask

`ifdef SEG_BLINK_EN
    initial bus.blink_mask = '0;
`endif

    initial begin
        test_reset();
        test_lz();
        test_hex();
        test_pwm();
        test_buffer();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
